// File: rtl/machine_mode_types_1_12_pkg.sv
// Shared machine-mode trap types: mcause exception codes, the per-lane
// cause priority order and the trap arbiter state encoding.
package machine_mode_types_1_12_pkg;

    localparam logic [3:0] CAUSE_MAL_INSN   = 4'd0;
    localparam logic [3:0] CAUSE_FAULT_INSN = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
    localparam logic [3:0] CAUSE_MAL_L      = 4'd4;
    localparam logic [3:0] CAUSE_FAULT_L    = 4'd5;
    localparam logic [3:0] CAUSE_MAL_S      = 4'd6;
    localparam logic [3:0] CAUSE_FAULT_S    = 4'd7;
    localparam logic [3:0] CAUSE_ECALL_U    = 4'd8;
    localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

    // Highest priority first.
    localparam int PRIO_N = 10;
    localparam logic [3:0] PRIO_ORDER [PRIO_N] = '{
        CAUSE_BREAKPOINT, CAUSE_FAULT_INSN, CAUSE_MAL_INSN, CAUSE_ILLEGAL,
        CAUSE_ECALL_U, CAUSE_ECALL_M, CAUSE_MAL_L, CAUSE_MAL_S,
        CAUSE_FAULT_L, CAUSE_FAULT_S
    };

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_REQ   = 2'd1;
    localparam state_t ST_WFI   = 2'd2;
    localparam state_t ST_FLUSH = 2'd3;

endpackage

// File: rtl/prv_exc_prio_enc.sv
// Per-lane exception priority encoder: picks the highest-priority set
// mcause bit; unranked codes fall back to the lowest set index.
module prv_exc_prio_enc
    import machine_mode_types_1_12_pkg::*;
#(
    parameter int EXC_W = 16
) (
    input  logic [EXC_W-1:0] exc,
    output logic             valid,
    output logic [3:0]       code
);

    always_comb begin
        valid = 1'b0;
        code  = 4'd0;
        for (int i = EXC_W - 1; i >= 0; i--) begin
            if (exc[i]) begin
                valid = 1'b1;
                code  = 4'(i);
            end
        end
        // Walk the ranked list backwards so the highest rank is written last.
        for (int p = PRIO_N - 1; p >= 0; p--) begin
            if (int'(PRIO_ORDER[p]) < EXC_W && exc[PRIO_ORDER[p]]) begin
                valid = 1'b1;
                code  = PRIO_ORDER[p];
            end
        end
    end

endmodule

// File: rtl/prv_trap_arbiter.sv
// Registered trap/return arbiter between the retirement lanes and the
// privilege block, with WFI sleep and a timed pipe-clear.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | lanes retire; kill mask follows the oldest event lane
// ST_REQ   | trap_req held with frozen request fields until insert_pc
// ST_WFI   | sleeping after WFI; wakes to an interrupt request on intr
// ST_FLUSH | pipe_clear for FLUSH_CYCLES cycles, redirect_pc = priv_pc
module prv_trap_arbiter
    import machine_mode_types_1_12_pkg::*;
#(
    parameter int NUM_LANES    = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int EXC_W        = 16
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NUM_LANES-1:0]    lane_valid,
    input  logic [NUM_LANES*EXC_W-1:0] lane_exc,
    input  logic [NUM_LANES-1:0]    lane_ret,
    input  logic [NUM_LANES-1:0]    lane_wfi,
    input  logic [NUM_LANES*32-1:0] lane_pc,
    input  logic [NUM_LANES*32-1:0] lane_badaddr,
    input  logic                    intr,
    input  logic                    insert_pc,
    input  logic [31:0]             priv_pc,
    output logic                    trap_req,
    output logic                    trap_is_intr,
    output logic                    trap_is_ret,
    output logic [3:0]              trap_cause,
    output logic [31:0]             epc,
    output logic [31:0]             badaddr,
    output logic [NUM_LANES-1:0]    lane_kill,
    output logic                    stall,
    output logic                    pipe_clear,
    output logic [31:0]             redirect_pc
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    state_t          state;
    logic [CW-1:0]   flush_cnt;
    logic            r_intr, r_ret;
    logic [3:0]      r_cause;
    logic [31:0]     r_epc, r_bad, r_redirect, last_pc, wfi_pc;

    logic [NUM_LANES-1:0] exc_v;
    logic [3:0]           exc_code [NUM_LANES];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_enc
        prv_exc_prio_enc #(.EXC_W(EXC_W)) u_enc (
            .exc   (lane_exc[g*EXC_W +: EXC_W]),
            .valid (exc_v[g]),
            .code  (exc_code[g])
        );
    end

    logic                 found, sel_exc, sel_ret;
    logic [3:0]           sel_code;
    logic [31:0]          sel_pc, sel_bad, oldest_pc, ret_pc;
    logic                 any_valid, ret_any;
    logic [NUM_LANES-1:0] kill_ev;

    // Scan from the oldest lane: first event wins, everything from it on is killed.
    always_comb begin
        found     = 1'b0;
        sel_exc   = 1'b0;
        sel_ret   = 1'b0;
        sel_code  = 4'd0;
        sel_pc    = 32'd0;
        sel_bad   = 32'd0;
        any_valid = 1'b0;
        oldest_pc = 32'd0;
        ret_any   = 1'b0;
        ret_pc    = 32'd0;
        kill_ev   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!found && lane_valid[i] && (exc_v[i] || lane_ret[i] || lane_wfi[i])) begin
                found    = 1'b1;
                sel_exc  = exc_v[i];
                sel_ret  = lane_ret[i];
                sel_code = exc_code[i];
                sel_pc   = lane_pc[i*32 +: 32];
                sel_bad  = lane_badaddr[i*32 +: 32];
            end
            kill_ev[i] = found;
            if (!found && lane_valid[i]) begin
                ret_any = 1'b1;
                ret_pc  = lane_pc[i*32 +: 32];
            end
            if (!any_valid && lane_valid[i]) begin
                any_valid = 1'b1;
                oldest_pc = lane_pc[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= ST_IDLE;
            flush_cnt  <= '0;
            r_intr     <= 1'b0;
            r_ret      <= 1'b0;
            r_cause    <= 4'd0;
            r_epc      <= 32'd0;
            r_bad      <= 32'd0;
            r_redirect <= 32'd0;
            last_pc    <= 32'd0;
            wfi_pc     <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (intr) begin
                        state   <= ST_REQ;
                        r_intr  <= 1'b1;
                        r_ret   <= 1'b0;
                        r_cause <= 4'd0;
                        r_epc   <= any_valid ? oldest_pc : last_pc + 32'd4;
                        r_bad   <= 32'd0;
                    end else if (found && sel_exc) begin
                        state   <= ST_REQ;
                        r_intr  <= 1'b0;
                        r_ret   <= 1'b0;
                        r_cause <= sel_code;
                        r_epc   <= sel_pc;
                        r_bad   <= sel_bad;
                    end else if (found && sel_ret) begin
                        state   <= ST_REQ;
                        r_intr  <= 1'b0;
                        r_ret   <= 1'b1;
                        r_cause <= 4'd0;
                        r_epc   <= sel_pc;
                        r_bad   <= 32'd0;
                    end else if (found) begin
                        state  <= ST_WFI;
                        wfi_pc <= sel_pc;
                    end
                    if (!intr && ret_any) begin
                        last_pc <= ret_pc;
                    end
                end
                ST_REQ: begin
                    if (insert_pc) begin
                        state      <= ST_FLUSH;
                        flush_cnt  <= CW'(FLUSH_CYCLES);
                        r_redirect <= priv_pc;
                        last_pc    <= priv_pc;
                    end
                end
                ST_WFI: begin
                    if (intr) begin
                        state   <= ST_REQ;
                        r_intr  <= 1'b1;
                        r_ret   <= 1'b0;
                        r_cause <= 4'd0;
                        r_epc   <= wfi_pc + 32'd4;
                        r_bad   <= 32'd0;
                    end
                end
                default: begin
                    // Saturating count so a stray zero can never wrap the timer.
                    if (flush_cnt <= CW'(1)) begin
                        state <= ST_IDLE;
                    end
                    if (flush_cnt != '0) begin
                        flush_cnt <= flush_cnt - CW'(1);
                    end
                end
            endcase
        end
    end

    assign trap_req     = (state == ST_REQ);
    assign trap_is_intr = r_intr;
    assign trap_is_ret  = r_ret;
    assign trap_cause   = r_cause;
    assign epc          = r_epc;
    assign badaddr      = r_bad;
    assign stall        = (state != ST_IDLE);
    assign pipe_clear   = (state == ST_FLUSH);
    assign redirect_pc  = r_redirect;
    assign lane_kill    = (state != ST_IDLE || intr) ? '1 : kill_ev;

endmodule
